// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path: request record and
// write-source tag used by the pending-destination scoreboard.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_XLEN    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests. Pointers carry one extra wrap bit
// so full/empty are distinguished without a counter. DEPTH must be a power of two.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    T            mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Owns the register-file write port: ALU results win, LSU results queue behind.
// Tracks pending long-latency destinations to stall issue. Macro WB_FWD_EN adds forwarding.
module reg_wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_wdata,
    input  logic                  iss_valid,
    input  logic                  iss_long,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_FWD_EN
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd_data,
`endif
    output logic [31:0]           pend_mask
);

    // Same shape as wb_req_t but sized to this instance's XLEN.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lq_req_t;

    lq_req_t lq_din;
    lq_req_t lq_head;
    logic    lq_full;
    logic    lq_empty;
    logic    lq_push;
    logic    lq_pop;
    wb_src_e rf_src;
    logic [31:0] pend;
    logic [31:0] pend_set;
    logic [31:0] pend_clr;
    logic        pend_hit;

    // No pass-through: a full queue refuses even if it drains this cycle.
    assign lsu_ready = !lq_full;
    assign lq_push   = lsu_valid && !lq_full;
    assign lq_pop    = !alu_valid && !lq_empty;
    assign lq_din    = '{rd: lsu_rd, data: lsu_wdata};

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .T     (lq_req_t)
    ) u_lq (
        .clk   (clk),
        .rst   (rst),
        .push  (lq_push),
        .pop   (lq_pop),
        .din   (lq_din),
        .dout  (lq_head),
        .full  (lq_full),
        .empty (lq_empty)
    );

    // x0 results are consumed but never raise the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            rf_src   <= WB_NONE;
        end else if (alu_valid) begin
            rf_we    <= (alu_rd != '0);
            rf_rd    <= alu_rd;
            rf_wdata <= alu_wdata;
            rf_src   <= WB_ALU;
        end else if (!lq_empty) begin
            rf_we    <= (lq_head.rd != '0);
            rf_rd    <= lq_head.rd;
            rf_wdata <= lq_head.data;
            rf_src   <= WB_LSU;
        end else begin
            rf_we    <= 1'b0;
            rf_src   <= WB_NONE;
        end
    end

    // Clear lands on the same edge the register file commits the LSU write.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (rf_we && rf_src == WB_LSU)
            pend_clr[rf_rd] = 1'b1;
        if (iss_valid && iss_long && !iss_stall && iss_rd != '0)
            pend_set[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pend <= '0;
        else
            pend <= ((pend & ~pend_clr) | pend_set) & ~32'd1;
    end

    assign pend_mask = pend;
    // pend[0] is held at 0, so x0 operands never match.
    assign pend_hit  = pend[iss_rs1] | pend[iss_rs2] | pend[iss_rd];

`ifdef WB_FWD_EN
    assign fwd1_hit  = rf_we && (rf_rd == iss_rs1) && (iss_rs1 != '0);
    assign fwd2_hit  = rf_we && (rf_rd == iss_rs2) && (iss_rs2 != '0);
    assign fwd_data  = rf_wdata;
    assign iss_stall = iss_valid && pend_hit;
`else
    // Without forwarding, a source read must wait out the uncommitted write.
    assign iss_stall = iss_valid &&
                       (pend_hit ||
                        (rf_we && rf_rd != '0 && (rf_rd == iss_rs1 || rf_rd == iss_rs2)));
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomised and directed bench for reg_wb_arbiter; writes are scoreboarded
// against a queue-based reference model, combinational outputs checked each cycle.
module tb_reg_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int LQ_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_wdata, lsu_wdata;
    logic        iss_valid, iss_long, iss_stall;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
`ifdef WB_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;
`endif

    reg_wb_arbiter #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .iss_valid(iss_valid), .iss_long(iss_long),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_FWD_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int   nchk = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;

    // Reference model: LSU queue contents, expected writes, pending set,
    // and the write currently sitting on the register-file port.
    ent_t        lq[$];
    ent_t        exq[$];
    logic [31:0] m_pend = '0;
    bit          m_wv = 1'b0, m_wlsu = 1'b0;
    logic [4:0]  m_wrd = '0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && rf_we !== 1'b0) begin
            if (exq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL wb_unexpected: got rf_we=%b rd=%0d data=%0h, expected no write at %0t",
                         rf_we, rf_rd, rf_wdata, $time);
            end else begin
                ent_t e;
                e = exq.pop_front();
                chk("wb_rd", 32'(rf_rd), 32'(e.rd));
                chk("wb_data", rf_wdata, e.data);
            end
        end
    end

    task automatic step(input bit r,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input bit iv, input bit il,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        output bit acc);
        bit   e_rdy, e_stl, nv, nlsu;
        ent_t nx;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_wdata = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_wdata = ld;
        iss_valid = iv; iss_long = il; iss_rs1 = s1; iss_rs2 = s2; iss_rd = d;
        #1;
        e_rdy = (lq.size() < LQ_DEPTH);
        e_stl = iv && ((s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2]) || (d != 0 && m_pend[d]));
`ifdef WB_FWD_EN
        chk("fwd1_hit", 32'(fwd1_hit), 32'(m_wv && m_wrd == s1 && s1 != 0));
        chk("fwd2_hit", 32'(fwd2_hit), 32'(m_wv && m_wrd == s2 && s2 != 0));
        if (m_wv) chk("fwd_data", fwd_data, m_wd);
`else
        if (iv && m_wv && (m_wrd == s1 || m_wrd == s2)) e_stl = 1'b1;
`endif
        chk("lsu_ready", 32'(lsu_ready), 32'(e_rdy));
        chk("iss_stall", 32'(iss_stall), 32'(e_stl));
        chk("pend_mask", pend_mask, m_pend);
        @(posedge clk);
        acc = lv && e_rdy && !r;
        if (r) begin
            lq.delete();
            m_pend = '0;
            m_wv = 1'b0;
            m_wlsu = 1'b0;
        end else begin
            if (m_wv && m_wlsu) m_pend[m_wrd] = 1'b0;
            if (iv && il && !e_stl && d != 0) m_pend[d] = 1'b1;
            nv = 1'b0; nlsu = 1'b0; nx = '0;
            if (av) begin
                nx = '{rd: ard, data: ad}; nv = 1'b1;
            end else if (lq.size() > 0) begin
                nx = lq.pop_front(); nv = 1'b1; nlsu = 1'b1;
            end
            if (lv && e_rdy) lq.push_back('{rd: lrd, data: ld});
            m_wv = nv && nx.rd != 0;
            m_wlsu = nlsu;
            m_wrd = nx.rd;
            m_wd = nx.data;
            if (m_wv) exq.push_back(nx);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        bit acc;
        int k;
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_wdata = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
        iss_valid = 0; iss_long = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we), 0);
        chk("reset_rf_rd", 32'(rf_rd), 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_pend", pend_mask, 0);
        chk("reset_ready", 32'(lsu_ready), 1);
        chk("reset_stall", 32'(iss_stall), 0);
        mon_en = 1'b1;

        // Mid-operation reset: one queued LSU entry and x5 pending.
        step(0, 1, 1, 32'h11, 1, 12, 32'hC0DE, 1, 1, 0, 0, 5, acc);
        step(1, 1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        #1;
        chk("midrst_rf_we", 32'(rf_we), 0);
        chk("midrst_pend", pend_mask, 0);
        chk("midrst_ready", 32'(lsu_ready), 1);
        idle(3);

        // ALU/LSU collision: ALU first, LSU one cycle later.
        step(0, 1, 3, 32'hAAAA, 1, 4, 32'h5555, 0, 0, 0, 0, 0, acc);
        idle(3);

        // Backpressure: ALU busy 5 cycles while LSU offers 3 results.
        k = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5'(10 + i), 32'(32'h100 + i), k < 3, 5'(20 + k), 32'(32'h200 + k),
                 0, 0, 0, 0, 0, acc);
            if (acc) k++;
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, k < 3, 5'(20 + k), 32'(32'h200 + k), 0, 0, 0, 0, 0, acc);
            if (acc) k++;
        end
        idle(3);

        // Scoreboard: long op to x7, dependent issue stalls until x7 commits.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 8, acc);
        step(0, 0, 0, 0, 1, 7, 32'h7777, 1, 0, 7, 0, 8, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 8, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, acc);
        idle(2);

        // Forwarding of a just-written ALU result.
        step(0, 1, 9, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 10, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 10, acc);
        idle(2);

        // x0 LSU result is consumed with no write.
        step(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, acc);
        idle(4);

        // Random traffic on a narrow register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 acc);
        end
        idle(8);
        chk("drain_expected_writes", 32'(exq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
